// File: rtl/imm_sequencer.sv
// ---------------------------------------------------------------------------
// imm_sequencer
//   Turns a stream of 32-bit instruction words into extended immediate
//   operands. A PREFIX word (in_instr[31:26] == 6'b111111) carries the upper
//   20 bits of a long immediate. The next non-prefix word supplies the low
//   12 bits, and the pair is issued as a single LONG32 operand.
//   Other words are decoded directly into one of four short formats.
//   The operand register is one entry deep. A new word can be accepted in
//   the same cycle that the held operand issues, so no bubble is inserted.
//
// Ports
//   clk        : clock; all state changes on its rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : an upstream instruction word is present
//   in_instr   : instruction word
//   in_ready   : the block accepts in_instr this cycle (combinational)
//   out_valid  : out_imm/out_fmt hold a valid operand
//   out_ready  : downstream consumes the operand this cycle
//   out_imm    : extended immediate operand
//   out_fmt    : format code (000 ZE5, 001 SE15, 010 ZE15, 011 SE20, 100 LONG32)
//   issue_cnt  : wrapping count of completed output transfers
//   pfx_err    : sticky flag; set when a prefix follows a prefix
// ---------------------------------------------------------------------------
module imm_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [31:0]      in_instr,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_imm,
    output logic [2:0]       out_fmt,
    output logic [CNT_W-1:0] issue_cnt,
    output logic             pfx_err
);

    localparam logic [2:0] FMT_ZE5    = 3'b000;
    localparam logic [2:0] FMT_SE15   = 3'b001;
    localparam logic [2:0] FMT_ZE15   = 3'b010;
    localparam logic [2:0] FMT_SE20   = 3'b011;
    localparam logic [2:0] FMT_LONG32 = 3'b100;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        PFX   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t      state;
    logic [19:0] prefix;

    logic        is_pfx;
    logic        accept;
    logic        issue;
    logic [31:0] dec_imm;
    logic [2:0]  dec_fmt;

    // Bits 25:20 carry no information for any format.
    logic        unused_bits;
    assign unused_bits = ^in_instr[25:20];

    assign is_pfx   = (in_instr[31:26] == 6'b111111);
    // While an operand is held, a new word fits only if the held one leaves.
    assign in_ready = (state != FULL) || out_ready;
    assign accept   = in_valid && in_ready;
    assign issue    = out_valid && out_ready;

    // Operand that a non-prefix word would produce in the current state.
    always_comb begin
        // NOTE: defaults first so that every path assigns every output and
        // no latch is inferred.
        dec_imm = 32'd0;
        dec_fmt = FMT_ZE5;
        if (state == PFX) begin
            dec_imm = {prefix, in_instr[11:0]};
            dec_fmt = FMT_LONG32;
        end else begin
            unique case (in_instr[31:30])
                2'b00: begin
                    dec_imm = {27'd0, in_instr[14:10]};
                    dec_fmt = FMT_ZE5;
                end
                2'b01: begin
                    dec_imm = {{17{in_instr[14]}}, in_instr[14:0]};
                    dec_fmt = FMT_SE15;
                end
                2'b10: begin
                    dec_imm = {17'd0, in_instr[14:0]};
                    dec_fmt = FMT_ZE15;
                end
                default: begin
                    dec_imm = {{12{in_instr[19]}}, in_instr[19:0]};
                    dec_fmt = FMT_SE20;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: all state, including the prefix register, is cleared by the
        // asynchronous reset so that no held prefix survives it.
        if (!rst_n) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            out_imm   <= 32'd0;
            out_fmt   <= FMT_ZE5;
            issue_cnt <= '0;
            pfx_err   <= 1'b0;
            prefix    <= 20'd0;
        end else begin
            // NOTE: non-blocking assignments keep every register updated from
            // pre-edge values regardless of statement order.
            if (issue) begin
                issue_cnt <= issue_cnt + 1'b1;
            end

            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        if (is_pfx) begin
                            prefix <= in_instr[19:0];
                            state  <= PFX;
                        end else begin
                            out_imm   <= dec_imm;
                            out_fmt   <= dec_fmt;
                            out_valid <= 1'b1;
                            state     <= FULL;
                        end
                    end
                end

                PFX: begin
                    if (accept) begin
                        if (is_pfx) begin
                            // A second prefix replaces the first and flags
                            // the broken pairing.
                            prefix  <= in_instr[19:0];
                            pfx_err <= 1'b1;
                        end else begin
                            out_imm   <= dec_imm;
                            out_fmt   <= dec_fmt;
                            out_valid <= 1'b1;
                            state     <= FULL;
                        end
                    end
                end

                FULL: begin
                    // In FULL, accept can only happen together with issue.
                    if (issue) begin
                        if (accept && !is_pfx) begin
                            out_imm <= dec_imm;
                            out_fmt <= dec_fmt;
                        end else if (accept) begin
                            prefix    <= in_instr[19:0];
                            out_valid <= 1'b0;
                            state     <= PFX;
                        end else begin
                            out_valid <= 1'b0;
                            state     <= EMPTY;
                        end
                    end
                end

                default: begin
                    out_valid <= 1'b0;
                    state     <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imm_sequencer.sv
// ---------------------------------------------------------------------------
// tb_imm_sequencer
//   Directed and randomised stimulus for imm_sequencer (CNT_W = 4, so the
//   counter wrap is reachable quickly). Expected values come from a
//   behavioural model that decodes words with plain integer arithmetic and
//   tracks "operand held" / "prefix held" as simple flags.
// ---------------------------------------------------------------------------
module tb_imm_sequencer;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [31:0]      in_instr;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_imm;
    logic [2:0]       out_fmt;
    logic [CNT_W-1:0] issue_cnt;
    logic             pfx_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit      m_full;
    bit      m_pfx;
    longint  m_pfxv;
    longint  m_imm;
    int      m_fmt;
    int      m_cnt;
    bit      m_err;

    imm_sequencer #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_fmt   (out_fmt),
        .issue_cnt (issue_cnt),
        .pfx_err   (pfx_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit word_is_prefix(input longint w);
        return (w / 67108864) == 63;   // top six bits all ones
    endfunction

    // Operand value as a non-negative 32-bit quantity.
    function automatic longint to_u32(input longint v);
        return (v < 0) ? v + 64'sd4294967296 : v;
    endfunction

    task automatic ref_decode(input longint w, input bit long_mode, input longint pv,
                              output longint imm, output int fmt);
        longint v;
        if (long_mode) begin
            imm = pv * 4096 + (w % 4096);
            fmt = 4;
        end else begin
            fmt = int'(w / 1073741824);
            case (fmt)
                0: imm = (w / 1024) % 32;
                1: begin
                    v = w % 32768;
                    if (v >= 16384) v -= 32768;
                    imm = to_u32(v);
                end
                2: imm = w % 32768;
                default: begin
                    v = w % 1048576;
                    if (v >= 524288) v -= 1048576;
                    imm = to_u32(v);
                end
            endcase
        end
    endtask

    task automatic model_reset();
        m_full = 0; m_pfx = 0; m_pfxv = 0; m_imm = 0; m_fmt = 0; m_cnt = 0; m_err = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, m_full});
        chk({tag, ".issue_cnt"}, {28'd0, issue_cnt}, m_cnt);
        chk({tag, ".pfx_err"}, {31'd0, pfx_err}, {31'd0, m_err});
        if (m_full) begin
            chk({tag, ".out_imm"}, out_imm, m_imm[31:0]);
            chk({tag, ".out_fmt"}, {29'd0, out_fmt}, m_fmt);
        end
    endtask

    // One clock: drive inputs after the falling edge, check the ready
    // handshake before the rising edge, check registered outputs after it.
    task automatic cycle(input bit v, input logic [31:0] instr, input bit r, input string tag);
        longint w;
        bit     acc;
        bit     iss;
        @(negedge clk);
        in_valid  = v;
        in_instr  = instr;
        out_ready = r;
        #1;
        chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, (!m_full || r)});
        w   = longint'(instr);
        acc = v && (!m_full || r);
        iss = m_full && r;
        @(posedge clk);
        if (iss) begin
            m_cnt  = (m_cnt + 1) % 16;
            m_full = 0;
        end
        if (acc) begin
            if (word_is_prefix(w)) begin
                if (m_pfx) m_err = 1;
                m_pfx  = 1;
                m_pfxv = w % 1048576;
            end else begin
                ref_decode(w, m_pfx, m_pfxv, m_imm, m_fmt);
                m_pfx  = 0;
                m_full = 1;
            end
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        // Reset must act before any clock edge.
        chk({tag, ".rst_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, ".rst_imm"}, out_imm, 32'd0);
        chk({tag, ".rst_fmt"}, {29'd0, out_fmt}, 32'd0);
        chk({tag, ".rst_cnt"}, {28'd0, issue_cnt}, 32'd0);
        chk({tag, ".rst_err"}, {31'd0, pfx_err}, 32'd0);
        model_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk({tag, ".rst_in_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] w;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_instr  = 32'd0;
        out_ready = 1'b0;
        model_reset();

        apply_reset("init");

        // Single SE15 operand, then its issue.
        cycle(1, 32'h4000_4001, 1, "se15");
        chk("se15.vec_imm", out_imm, 32'hFFFF_C001);
        chk("se15.vec_fmt", {29'd0, out_fmt}, 32'd1);
        cycle(0, 32'd0, 1, "se15_issue");
        chk("se15.vec_cnt", {28'd0, issue_cnt}, 32'd1);

        // ZE5 and SE20.
        cycle(1, 32'h0000_7C00, 1, "ze5");
        chk("ze5.vec_imm", out_imm, 32'h0000_001F);
        cycle(1, 32'hC008_0000, 1, "se20");
        chk("se20.vec_imm", out_imm, 32'hFFF8_0000);
        chk("se20.vec_fmt", {29'd0, out_fmt}, 32'd3);
        cycle(0, 32'd0, 1, "se20_issue");

        // Long immediate: prefix + low part form a single operand.
        cycle(1, 32'hFC0A_BCDE, 1, "long_pfx");
        cycle(1, 32'h8000_0F12, 1, "long_lo");
        chk("long.vec_imm", out_imm, 32'hABCD_EF12);
        chk("long.vec_fmt", {29'd0, out_fmt}, 32'd4);
        cycle(0, 32'd0, 1, "long_issue");

        // Backpressure: operand must hold steady, then drain without a bubble.
        cycle(1, 32'h8000_1234, 1, "bp_fill");
        for (int i = 0; i < 5; i++) begin
            cycle(1, 32'h0000_0400, 0, "bp_hold");
            chk("bp.hold_imm", out_imm, 32'h0000_1234);
        end
        cycle(1, 32'h0000_0400, 1, "bp_release");
        chk("bp.next_imm", out_imm, 32'h0000_0001);
        cycle(0, 32'd0, 1, "bp_drain");
        cycle(0, 32'd0, 1, "bp_idle");

        // Double prefix sets the sticky error; the second prefix wins.
        cycle(1, 32'hFC01_1111, 1, "dp_pfx1");
        cycle(1, 32'hFC02_2222, 1, "dp_pfx2");
        chk("dp.err_set", {31'd0, pfx_err}, 32'd1);
        cycle(1, 32'h8000_0333, 1, "dp_lo");
        chk("dp.vec_imm", out_imm, 32'h2222_2333);
        for (int i = 0; i < 4; i++) begin
            cycle(1, 32'h4000_0007, 1, "dp_after");
        end
        chk("dp.err_sticky", {31'd0, pfx_err}, 32'd1);

        // Reset while an operand is held.
        cycle(1, 32'h4000_0005, 0, "rst_fill");
        apply_reset("rst_full");

        // 17 issues on a 4-bit counter wrap back to 1.
        for (int i = 0; i < 18; i++) begin
            w = $urandom;
            cycle(1, {2'b00, w[29:0]}, 1, "wrap");
        end
        chk("wrap.cnt", {28'd0, issue_cnt}, 32'd1);

        // Randomised traffic with prefixes and random backpressure.
        apply_reset("rand_start");
        for (int i = 0; i < 400; i++) begin
            w = $urandom;
            if ($urandom_range(3) == 0) w[31:26] = 6'b111111;
            cycle(bit'($urandom_range(1)), w, bit'($urandom_range(3) != 0), "rand");
        end
        apply_reset("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
